// File: rtl/mem_arb.sv
// Memory arbiter/sequencer between the LC-3 CPU port and a DMA/loader port.
// One access at a time, fixed wait-state window, alternating priority on contention.
module mem_arb #(
   parameter int unsigned WAIT_CYC = 2,
   parameter int unsigned AW       = 16,
   parameter int unsigned DW       = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_en,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ready,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_ack,
   output logic          mem_ce,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   localparam logic       GntCpu  = 1'b0;
   localparam logic       GntDma  = 1'b1;
   localparam logic [3:0] LastCnt = 4'(WAIT_CYC - 1);

   state_e        state_q, state_d;
   logic          gnt_q, gnt_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          last_gnt_q, last_gnt_d;
   logic          pick_dma;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         gnt_q      <= GntCpu;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         rdata_q    <= '0;
         last_gnt_q <= GntDma;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      last_gnt_d = last_gnt_q;
      // DMA wins if alone, or on contention when the CPU was served last.
      pick_dma   = dma_req && (!cpu_en || (last_gnt_q == GntCpu));
      unique case (state_q)
         StIdle: begin
            if (cpu_en || dma_req) begin
               gnt_d   = pick_dma ? GntDma : GntCpu;
               we_d    = pick_dma ? dma_we : cpu_we;
               addr_d  = pick_dma ? dma_addr : cpu_addr;
               wdata_d = pick_dma ? dma_wdata : cpu_wdata;
               cnt_d   = '0;
               state_d = StAccess;
            end
         end
         StAccess: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LastCnt) begin
               if (!we_q) rdata_d = mem_rdata;
               state_d = StDone;
            end
         end
         StDone: begin
            last_gnt_d = gnt_q;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mem_ce    = 1'b0;
      mem_we    = 1'b0;
      cpu_ready = 1'b0;
      dma_ack   = 1'b0;
      unique case (state_q)
         StIdle: ;
         StAccess: begin
            mem_ce = 1'b1;
            mem_we = we_q;
         end
         StDone: begin
            cpu_ready = (gnt_q == GntCpu);
            dma_ack   = (gnt_q == GntDma);
         end
         default: ;
      endcase
   end

   assign busy      = (state_q != StIdle);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_rdata = rdata_q;
   assign dma_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb (WAIT_CYC=2). Memory model returns addr ^ x2234,
// so x3000 -> x1234, x4000 -> x6234.
module tb_mem_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_en, cpu_we, dma_req, dma_we;
   logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_ready, dma_ack, mem_ce, mem_we, busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign mem_rdata = mem_addr ^ 16'h2234;

   mem_arb #(.WAIT_CYC(2), .AW(16), .DW(16)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_en    (cpu_en),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_rdata (dma_rdata),
      .dma_ack   (dma_ack),
      .mem_ce    (mem_ce),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   int cpu_cnt, dma_cnt;

   initial begin
      rst_n = 1'b0;
      cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      step(); step();
      check("rst_mem_ce", 32'(mem_ce), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_rdata", 32'(cpu_rdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pulses", 32'({cpu_ready, dma_ack}), 32'd0);
      rst_n = 1'b1;
      step();

      // CPU read of x3000
      cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
      step();
      check("rd_ce_t1", 32'({mem_ce, mem_we, busy}), 32'b101);
      check("rd_addr_t1", 32'(mem_addr), 32'h3000);
      check("rd_ready_t1", 32'(cpu_ready), 32'd0);
      step();
      check("rd_ce_t2", 32'(mem_ce), 32'd1);
      step();
      check("rd_ready_t3", 32'({cpu_ready, dma_ack, mem_ce}), 32'b100);
      check("rd_data_t3", 32'(cpu_rdata), 32'h1234);
      cpu_en = 1'b0;
      step();
      check("rd_idle_t4", 32'({cpu_ready, busy}), 32'd0);

      // CPU write x00FF to xFE06
      cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFE06; cpu_wdata = 16'h00FF;
      step();
      check("wr_ce_t1", 32'({mem_ce, mem_we}), 32'b11);
      check("wr_bus_t1", {mem_addr, mem_wdata}, 32'hFE06_00FF);
      step();
      check("wr_ce_t2", 32'({mem_ce, mem_we}), 32'b11);
      step();
      check("wr_ready_t3", 32'({cpu_ready, mem_ce, mem_we}), 32'b100);
      check("wr_rdata_kept", 32'(cpu_rdata), 32'h1234);
      cpu_en = 1'b0; cpu_we = 1'b0;
      step();
      check("wr_no_repulse", 32'(cpu_ready), 32'd0);

      // Fresh reset so last_gnt is DMA again, then four contended transfers
      rst_n = 1'b0; step(); rst_n = 1'b1; step();
      cpu_en = 1'b1; cpu_addr = 16'h3000;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h4000;
      cpu_cnt = 0; dma_cnt = 0;
      for (int c = 1; c <= 16; c++) begin
         step();
         cpu_cnt += int'(cpu_ready);
         dma_cnt += int'(dma_ack);
         if (c % 4 == 3) begin
            check($sformatf("arb_order_%0d", c / 4), 32'({cpu_ready, dma_ack}),
                  ((c / 4) % 2 == 0) ? 32'b10 : 32'b01);
            check($sformatf("arb_data_%0d", c / 4), 32'(cpu_rdata),
                  ((c / 4) % 2 == 0) ? 32'h1234 : 32'h6234);
            if (c == 15) begin
               cpu_en = 1'b0; dma_req = 1'b0;
            end
         end else if (c % 4 == 0) begin
            check($sformatf("arb_gap_%0d", c / 4), 32'({mem_ce, busy}), 32'd0);
         end
      end
      check("arb_cpu_pulses", 32'(cpu_cnt), 32'd2);
      check("arb_dma_pulses", 32'(dma_cnt), 32'd2);

      // CPU holds cpu_en for 3 cycles after cpu_ready: one fresh re-grant
      cpu_en = 1'b1; cpu_addr = 16'h3000;
      cpu_cnt = 0;
      for (int c = 1; c <= 10; c++) begin
         step();
         cpu_cnt += int'(cpu_ready);
         if (c == 3) check("rg_ready_1", 32'(cpu_ready), 32'd1);
         if (c == 4) check("rg_idle", 32'({cpu_ready, mem_ce, busy}), 32'd0);
         if (c == 5) check("rg_ce", 32'(mem_ce), 32'd1);
         if (c == 6) cpu_en = 1'b0;
         if (c == 7) check("rg_ready_2", 32'(cpu_ready), 32'd1);
      end
      check("rg_pulse_count", 32'(cpu_cnt), 32'd2);

      // DMA changes its address mid-access
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h4000;
      step();
      check("dma_addr_t1", 32'(mem_addr), 32'h4000);
      dma_addr = 16'h5000;
      step();
      check("dma_addr_t2", 32'({15'd0, mem_ce, mem_addr}), 32'h1_4000);
      step();
      check("dma_ack_t3", 32'({cpu_ready, dma_ack}), 32'b01);
      check("dma_data_t3", 32'(dma_rdata), 32'h6234);
      dma_req = 1'b0;
      step();

      // Reset during the second access cycle
      cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
      step();
      step();
      check("rr_ce_before", 32'(mem_ce), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rr_ce_async", 32'({mem_ce, mem_we, busy}), 32'd0);
      check("rr_rdata_rst", 32'(cpu_rdata), 32'd0);
      step();
      check("rr_no_ack", 32'({cpu_ready, dma_ack}), 32'd0);
      rst_n = 1'b1;
      step();
      check("rr_ce_r1", 32'({mem_ce, cpu_ready}), 32'b10);
      step();
      check("rr_ce_r2", 32'({mem_ce, cpu_ready}), 32'b10);
      step();
      check("rr_ready_r3", 32'({cpu_ready, mem_ce}), 32'b10);
      check("rr_data_r3", 32'(cpu_rdata), 32'h1234);
      cpu_en = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
